digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Multi-cycle, parametrised add/subtract unit that processes a WIDTH-bit operand pair DIGIT bits per clock through a chain of DIGIT one-bit full-adder cells, with a registered carry between cycles. It is the shared accumulate stage for the sequential multiplier datapaths in the lab, where adder area matters more than latency. A ready/start/done handshake frames each operation, and results are held until the next accepted start.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 2, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0 (elaboration error otherwise).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only on an edge where ready=1.
- sub  in  1  0 computes a+b; 1 computes a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- ready  out  1  high when the FSM is in IDLE.
- busy  out  1  high when the FSM is in RUN.
- done  out  1  one-cycle pulse: the result is valid from this cycle on.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For subtract: 1 means no borrow (a ≥ b unsigned).
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- N = WIDTH/DIGIT digit cycles per operation.
- FSM states:
  - IDLE: ready=1. An edge with start=1 latches a into the A shift register, latches (sub ? ~b : b) into the B shift register, sets carry=sub and digit counter=0, then moves to RUN.
  - RUN: busy=1. Each edge adds the low DIGIT bits of A, B and carry, then:
    - shifts A and B right by DIGIT;
    - shifts the digit sum into the top of the internal partial-sum register;
    - updates carry;
    - increments the counter.
  - On the edge that processes digit N−1, the FSM moves to DONE and registers the final sum, cout and ovf into the outputs. ovf uses the carry into and out of bit WIDTH−1 within that last digit.
  - DONE: done=1 for exactly one cycle, then unconditionally returns to IDLE.
- start is ignored while in RUN or DONE. No queueing, no error flag.
- sum, cout and ovf change only on the completion edge. They hold their value through IDLE and the following RUN until the next completion.
- Inputs a, b and sub may change freely after acceptance with no effect on the operation in flight.
- Exactly one of ready, busy and done is high in every cycle.

## Timing
- Reset (rst_n=0 on an edge) gives: state IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, internal registers and counter cleared.
- Reset during RUN or DONE aborts the operation: no done pulse, outputs cleared.
- start held high during reset is ignored. The earliest acceptance is the first edge with rst_n=1.
- With start accepted on edge k:
  - busy is high in the cycles following edges k … k+N−1;
  - done and the new outputs appear after edge k+N;
  - ready returns after edge k+N+1.
- Throughput is one operation per N+2 cycles.
- DIGIT=WIDTH gives N=1: RUN lasts one cycle.
- The critical path is DIGIT full-adder cells plus the carry register setup. No combinational path exists from any input to any output.

## Test plan
- WIDTH=8, DIGIT=2, a=8'h5A, b=8'h3C, sub=0 → sum=8'h96, cout=0, ovf=1; done exactly 4 cycles after the accept edge; busy high for 4 cycles.
- WIDTH=8, DIGIT=2, subtract cases:
  - a=8'h10, b=8'h20, sub=1 → sum=8'hF0, cout=0, ovf=0.
  - a=8'h80, b=8'h01, sub=1 → sum=8'h7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=2, a=8'hFF, b=8'h01, sub=0 → sum=8'h00, cout=1, ovf=0.
  - Re-pulse start with new operands in every RUN and DONE cycle: all such starts are ignored and the result is unchanged.
  - Operands changed after acceptance: no effect on the result.
- Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle of a busy op → next cycle ready=1, sum=0, cout=0, ovf=0, and no done pulse at any point.
- Parameter sweep (WIDTH,DIGIT) ∈ {(8,1), (8,8), (16,4)}, 1000 random a/b/sub each, checked against a reference a±b model → sum, cout and ovf all match; done latency = WIDTH/DIGIT cycles.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: DIGIT full-adder cells per clock with a registered
// carry, framed by a ready/start/done handshake; results hold until the next completion.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] areg, breg, psum, psum_next, sext;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   c;
  logic             last;

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ripple chain of DIGIT full-adder cells; the digit sum enters psum from the top.
  always_comb begin
    c[0] = carry;
    dsum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = areg[i] ^ breg[i] ^ c[i];
      c[i + 1] = (areg[i] & breg[i]) | (c[i] & (areg[i] ^ breg[i]));
    end
    sext              = '0;
    sext[DIGIT-1:0]   = dsum;
    psum_next         = (psum >> DIGIT) | (sext << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      areg  <= '0;
      breg  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            areg  <= a;
            breg  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          areg  <= areg >> DIGIT;
          breg  <= breg >> DIGIT;
          psum  <= psum_next;
          carry <= c[DIGIT];
          cnt   <= cnt + CW'(1);
          // Overflow compares the carries into and out of the MSB cell of the last digit.
          if (last) begin
            sum  <= psum_next;
            cout <= c[DIGIT];
            ovf  <= c[DIGIT] ^ c[DIGIT-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: four parameter configurations run in parallel,
// expected results come from a plain-arithmetic a+/-b model and are popped on each done.
module tb_digit_serial_adder;

  localparam int NCFG  = 4;
  localparam int CFGW [NCFG] = '{8, 8, 8, 16};
  localparam int CFGD [NCFG] = '{2, 1, 8, 4};
  localparam int NRAND = 1000;

  typedef struct {
    int     cfg;
    int     acc;
    longint sum;
    bit     cout;
    bit     ovf;
  } exp_t;

  bit              clk;
  logic [NCFG-1:0] rstN, start, sub, ready, busy, done, cout, ovf;
  logic [15:0]     aIn    [NCFG];
  logic [15:0]     bIn    [NCFG];
  logic [15:0]     sumOut [NCFG];

  int              cyc;
  int              nCompared, nMismatched;
  exp_t            sb[$];
  bit [NCFG-1:0]   finished, stimTimeout, postReset;
  bit              ended;
  longint          heldSum  [NCFG];
  bit              heldCout [NCFG];
  bit              heldOvf  [NCFG];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < NCFG; g++) begin : cfg
      digit_serial_adder #(.WIDTH(CFGW[g]), .DIGIT(CFGD[g])) dut (
        .clk  (clk),
        .rst_n(rstN[g]),
        .start(start[g]),
        .sub  (sub[g]),
        .a    (aIn[g][CFGW[g]-1:0]),
        .b    (bIn[g][CFGW[g]-1:0]),
        .ready(ready[g]),
        .busy (busy[g]),
        .done (done[g]),
        .sum  (sumOut[g][CFGW[g]-1:0]),
        .cout (cout[g]),
        .ovf  (ovf[g])
      );
      if (CFGW[g] < 16) begin : pad
        assign sumOut[g][15:CFGW[g]] = '0;
      end
    end
  endgenerate

  // Reference: unsigned and signed arithmetic on whole operands.
  function automatic exp_t model(input int g, input longint va, input longint vb, input bit vs);
    exp_t   e;
    int     w    = CFGW[g];
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint sa, sbv, sr;
    sa  = (va >= half) ? va - (m + 1) : va;
    sbv = (vb >= half) ? vb - (m + 1) : vb;
    if (vs) begin
      e.sum  = (va - vb) & m;
      e.cout = (va >= vb);
      sr     = sa - sbv;
    end else begin
      e.sum  = (va + vb) & m;
      e.cout = ((va + vb) > m);
      sr     = sa + sbv;
    end
    e.ovf = (sr < -half) || (sr >= half);
    e.cfg = g;
    e.acc = 0;
    return e;
  endfunction

  task automatic checkOutput(input int g, input string name, input longint act, input longint req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL cfg%0d %s: got %0h, expected %0h (cycle %0d)", g, name, act, req, cyc);
    end
  endtask

  task automatic randOperands(input int g);
    longint m = (longint'(1) << CFGW[g]) - 1;
    aIn[g] = 16'(longint'({$urandom(), $urandom()}) & m);
    bIn[g] = 16'(longint'({$urandom(), $urandom()}) & m);
    sub[g] = 1'($urandom_range(0, 1));
  endtask

  task automatic waitReady(input int g);
    int k = 0;
    @(negedge clk);
    while (!ready[g] && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!ready[g]) stimTimeout[g] = 1'b1;
  endtask

  task automatic acceptNow(input int g);
    exp_t e;
    @(posedge clk);
    #1;
    e     = model(g, longint'(aIn[g]), longint'(bIn[g]), sub[g]);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  // Keeps re-pulsing start with fresh operands through every RUN and DONE cycle.
  task automatic drain(input int g);
    int n = CFGW[g] / CFGD[g];
    for (int j = 0; j <= n; j++) begin
      start[g] = 1'($urandom_range(0, 1));
      randOperands(g);
      @(posedge clk);
      #1;
    end
    start[g] = 1'b0;
  endtask

  task automatic applyStimulus(input int g, input longint va, input longint vb, input bit vs);
    waitReady(g);
    aIn[g]   = 16'(va);
    bIn[g]   = 16'(vb);
    sub[g]   = vs;
    start[g] = 1'b1;
    acceptNow(g);
    drain(g);
  endtask

  task automatic abortOp(input int g);
    int n = CFGW[g] / CFGD[g];
    int r = (n < 2) ? 1 : 2;
    waitReady(g);
    randOperands(g);
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    repeat (r - 1) begin
      @(posedge clk);
      #1;
    end
    rstN[g] = 1'b0;
    @(posedge clk);
    #1;
    rstN[g] = 1'b1;
  endtask

  task automatic runConfig(input int g);
    longint m    = (longint'(1) << CFGW[g]) - 1;
    longint half = longint'(1) << (CFGW[g] - 1);
    longint dA [6] = '{'h5A, 'h10, 'h80, 'hFF, 0, 0};
    longint dB [6] = '{'h3C, 'h20, 'h01, 'h01, 1, 1};
    bit     dS [6] = '{0, 1, 1, 0, 0, 1};
    dA[4] = m;
    dA[5] = half;
    // start is held high through reset; the first edge after release must accept it.
    randOperands(g);
    start[g] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstN[g] = 1'b1;
    acceptNow(g);
    drain(g);
    for (int i = 0; i < 6; i++) applyStimulus(g, dA[i] & m, dB[i] & m, dS[i]);
    abortOp(g);
    for (int i = 0; i < NRAND; i++) begin
      randOperands(g);
      applyStimulus(g, longint'(aIn[g]), longint'(bIn[g]), sub[g]);
    end
    finished[g] = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NCFG; g++) begin
      int   idx;
      exp_t e;
      checkOutput(g, "one-hot ready/busy/done", int'(ready[g]) + int'(busy[g]) + int'(done[g]), 1);
      checkOutput(g, "ready wait timeout", longint'(stimTimeout[g]), 0);
      if (postReset[g]) begin
        checkOutput(g, "ready after reset", longint'(ready[g]), 1);
        postReset[g] = 1'b0;
      end
      if (done[g]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].cfg == g) begin
            idx = i;
            break;
          end
        end
        if (idx < 0) begin
          checkOutput(g, "spurious done", longint'(done[g]), 0);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          checkOutput(g, "sum", longint'(sumOut[g]), e.sum);
          checkOutput(g, "cout", longint'(cout[g]), longint'(e.cout));
          checkOutput(g, "ovf", longint'(ovf[g]), longint'(e.ovf));
          checkOutput(g, "done latency", cyc - e.acc, CFGW[g] / CFGD[g]);
          heldSum[g]  = e.sum;
          heldCout[g] = e.cout;
          heldOvf[g]  = e.ovf;
        end
      end else begin
        checkOutput(g, "held sum", longint'(sumOut[g]), heldSum[g]);
        checkOutput(g, "held cout", longint'(cout[g]), longint'(heldCout[g]));
        checkOutput(g, "held ovf", longint'(ovf[g]), longint'(heldOvf[g]));
      end
      if (!rstN[g]) begin
        heldSum[g]   = 0;
        heldCout[g]  = 1'b0;
        heldOvf[g]   = 1'b0;
        postReset[g] = 1'b1;
      end
    end
    if (&finished && !ended) begin
      checkOutput(0, "results never delivered", sb.size(), 0);
      ended = 1'b1;
    end
  end

  initial begin
    rstN  = '0;
    start = '0;
    sub   = '0;
    for (int g = 0; g < NCFG; g++) begin
      aIn[g] = '0;
      bIn[g] = '0;
    end
    for (int g = 0; g < NCFG; g++) begin
      fork
        automatic int gg = g;
        runConfig(gg);
      join_none
    end
    wait fork;
    wait (ended);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not complete, compared %0d mismatched %0d", nCompared, nMismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
